// File: rtl/apb_rr_arbiter_if.sv
// Signal bundle for apb_rr_arbiter: two upstream APB requesters, one downstream completer and status.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface apb_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [1:0]              up_psel;
  logic [1:0]              up_penable;
  logic [1:0]              up_pwrite;
  logic [2*ADDR_WIDTH-1:0] up_paddr;
  logic [2*DATA_WIDTH-1:0] up_pwdata;
  logic [2*STRB_WIDTH-1:0] up_pstrb;
  logic [1:0]              up_pready;
  logic [DATA_WIDTH-1:0]   up_prdata;
  logic                    up_pslverr;

  logic                    dn_psel;
  logic                    dn_penable;
  logic                    dn_pwrite;
  logic [ADDR_WIDTH-1:0]   dn_paddr;
  logic [DATA_WIDTH-1:0]   dn_pwdata;
  logic [STRB_WIDTH-1:0]   dn_pstrb;
  logic [DATA_WIDTH-1:0]   dn_prdata;
  logic                    dn_pready;
  logic                    dn_pslverr;

  logic                    grant;
  logic                    busy;

  modport slave (
    input  up_psel, up_penable, up_pwrite, up_paddr, up_pwdata, up_pstrb,
    input  dn_prdata, dn_pready, dn_pslverr,
    output up_pready, up_prdata, up_pslverr,
    output dn_psel, dn_penable, dn_pwrite, dn_paddr, dn_pwdata, dn_pstrb,
    output grant, busy
  );

  modport master (
    output up_psel, up_penable, up_pwrite, up_paddr, up_pwdata, up_pstrb,
    output dn_prdata, dn_pready, dn_pslverr,
    input  up_pready, up_prdata, up_pslverr,
    input  dn_psel, dn_penable, dn_pwrite, dn_paddr, dn_pwdata, dn_pstrb,
    input  grant, busy
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// 2:1 round-robin APB arbiter, fully registered, one transfer in flight (IDLE->SETUP->ACCESS->RESP).
// Optional ACCESS-phase abort after TIMEOUT_CYCLES is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            pclk,
  input  logic            preset_n,
  apb_rr_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            r_state;
  logic                  r_last_grant;
  logic                  r_grant;
  logic                  r_dn_psel;
  logic                  r_dn_penable;
  logic                  r_dn_pwrite;
  logic [ADDR_WIDTH-1:0] r_dn_paddr;
  logic [DATA_WIDTH-1:0] r_dn_pwdata;
  logic [STRB_WIDTH-1:0] r_dn_pstrb;
  logic [1:0]            r_up_pready;
  logic [DATA_WIDTH-1:0] r_up_prdata;
  logic                  r_up_pslverr;

  logic                  w_winner;
  logic                  w_abort;
  logic                  w_unused;
  logic                  w_pwrite;
  logic [ADDR_WIDTH-1:0] w_paddr;
  logic [DATA_WIDTH-1:0] w_pwdata;
  logic [STRB_WIDTH-1:0] w_pstrb;

  // A lone requester wins outright; on a tie the one not served last wins.
  assign w_winner = bus.up_psel[1] & (~bus.up_psel[0] | ~r_last_grant);

  assign w_pwrite = bus.up_pwrite[w_winner];
  assign w_paddr  = w_winner ? bus.up_paddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                             : bus.up_paddr[ADDR_WIDTH-1:0];
  assign w_pwdata = w_winner ? bus.up_pwdata[2*DATA_WIDTH-1:DATA_WIDTH]
                             : bus.up_pwdata[DATA_WIDTH-1:0];
  assign w_pstrb  = w_winner ? bus.up_pstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                             : bus.up_pstrb[STRB_WIDTH-1:0];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_ACCESS && !bus.dn_pready) begin
      r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end
  end

  // The counter holds completed stalled cycles; the one that would reach the limit aborts.
  assign w_abort  = (r_state == ST_ACCESS) && !bus.dn_pready && (r_tmo_cnt == TMO_LAST);
  assign w_unused = ^bus.up_penable;
`else
  assign w_abort  = 1'b0;
  assign w_unused = (^bus.up_penable) ^ (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_dn_psel    <= 1'b0;
      r_dn_penable <= 1'b0;
      r_dn_pwrite  <= 1'b0;
      r_dn_paddr   <= '0;
      r_dn_pwdata  <= '0;
      r_dn_pstrb   <= '0;
      r_up_pready  <= 2'b00;
      r_up_prdata  <= '0;
      r_up_pslverr <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block sees pre-edge state.
      r_up_pready <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (|bus.up_psel) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_dn_pwrite  <= w_pwrite;
            r_dn_paddr   <= w_paddr;
            r_dn_pwdata  <= w_pwdata;
            r_dn_pstrb   <= w_pstrb;
            r_dn_psel    <= 1'b1;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_dn_penable <= 1'b1;
          r_state      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.dn_pready || w_abort) begin
            r_dn_psel    <= 1'b0;
            r_dn_penable <= 1'b0;
            r_up_pready  <= r_grant ? 2'b10 : 2'b01;
            r_up_prdata  <= bus.dn_pready ? bus.dn_prdata : '0;
            r_up_pslverr <= bus.dn_pready ? bus.dn_pslverr : 1'b1;
            r_state      <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dn_psel    = r_dn_psel;
  assign bus.dn_penable = r_dn_penable;
  assign bus.dn_pwrite  = r_dn_pwrite;
  assign bus.dn_paddr   = r_dn_paddr;
  assign bus.dn_pwdata  = r_dn_pwdata;
  assign bus.dn_pstrb   = r_dn_pstrb;
  assign bus.up_pready  = r_up_pready;
  assign bus.up_prdata  = r_up_prdata;
  assign bus.up_pslverr = r_up_pslverr;
  assign bus.grant      = r_grant;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: an edge-indexed transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations (timeout scenarios need APB_ARB_TIMEOUT_EN).
module tb_apb_rr_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TMO = 8;

  logic pclk;
  logic preset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  apb_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Completer: ready after c_waits stalled ACCESS cycles, or never when c_never is set.
  int          c_waits = 0;
  bit          c_never = 1'b0;
  logic [31:0] c_data  = 32'h0;
  logic        c_err   = 1'b0;
  int          c_cnt   = 0;

  always @(negedge pclk) begin
    bus.dn_prdata  = c_data;
    bus.dn_pslverr = c_err;
    if (bus.dn_psel && bus.dn_penable && !c_never && c_cnt == c_waits) begin
      bus.dn_pready = 1'b1;
    end else begin
      bus.dn_pready = 1'b0;
      if (bus.dn_psel && bus.dn_penable) c_cnt++;
      else                               c_cnt = 0;
    end
  end

  // Transaction model: a transfer is granted on edge g, shows SETUP after g, ACCESS after g+1,
  // completes on the first edge >= g+2 that sees dn_pready (or aborts once TMO ACCESS cycles
  // have elapsed), responds for one cycle and is gone on the following edge.
  int          m_edge     = 0;
  int          m_gnt_edge = 0;
  bit          m_active   = 1'b0;
  bit          m_resp     = 1'b0;
  bit          m_owner    = 1'b0;
  bit          m_last     = 1'b1;
  logic        m_pwrite   = 1'b0;
  logic [15:0] m_paddr    = '0;
  logic [31:0] m_pwdata   = '0;
  logic [3:0]  m_pstrb    = '0;
  logic [31:0] m_prdata   = '0;
  logic        m_pslverr  = 1'b0;

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      m_edge = 0; m_active = 0; m_resp = 0; m_owner = 0; m_last = 1;
      m_pwrite = 0; m_paddr = '0; m_pwdata = '0; m_pstrb = '0; m_prdata = '0; m_pslverr = 0;
    end else begin
      m_edge++;
      if (m_resp) begin
        m_resp   = 1'b0;
        m_active = 1'b0;
      end else if (m_active) begin
        if (m_edge >= m_gnt_edge + 2) begin
          if (bus.dn_pready) begin
            m_resp = 1'b1; m_prdata = bus.dn_prdata; m_pslverr = bus.dn_pslverr;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (m_edge - m_gnt_edge - 1 == TMO) begin
            m_resp = 1'b1; m_prdata = '0; m_pslverr = 1'b1;
          end
`endif
        end
      end else if (bus.up_psel != 2'b00) begin
        m_owner    = (bus.up_psel == 2'b11) ? !m_last : bus.up_psel[1];
        m_last     = m_owner;
        m_active   = 1'b1;
        m_gnt_edge = m_edge;
        m_pwrite   = bus.up_pwrite[m_owner];
        m_paddr    = bus.up_paddr[m_owner*AW +: AW];
        m_pwdata   = bus.up_pwdata[m_owner*DW +: DW];
        m_pstrb    = bus.up_pstrb[m_owner*4 +: 4];
      end
    end
  end

  always @(negedge pclk) begin
    check("m_busy",       bus.busy,       m_active);
    check("m_dn_psel",    bus.dn_psel,    m_active && !m_resp);
    check("m_dn_penable", bus.dn_penable, m_active && !m_resp && (m_edge > m_gnt_edge));
    check("m_up_pready",  bus.up_pready,  m_resp ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
    check("m_grant",      bus.grant,      m_owner);
    check("m_dn_pwrite",  bus.dn_pwrite,  m_pwrite);
    check("m_dn_paddr",   bus.dn_paddr,   m_paddr);
    check("m_dn_pwdata",  bus.dn_pwdata,  m_pwdata);
    check("m_dn_pstrb",   bus.dn_pstrb,   m_pstrb);
    check("m_up_prdata",  bus.up_prdata,  m_prdata);
    check("m_up_pslverr", bus.up_pslverr, m_pslverr);
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bus.up_pwrite[i]        = wr;
    bus.up_paddr[i*AW +: AW] = a;
    bus.up_pwdata[i*DW +: DW] = d;
    bus.up_pstrb[i*4 +: 4]   = s;
  endtask

  // Counts edges from the call until up_pready is seen; the first edge is the grant edge.
  task automatic wait_pready(input int limit, output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (bus.up_pready == 2'b00 && lat < limit);
    check("pready_within_limit", bus.up_pready != 2'b00, 1);
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    repeat (2) cyc();
    preset_n = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int g[8];
    int t[8];
    logic [15:0] a[8];
    logic prev;

    preset_n       = 1'b0;
    bus.up_psel    = 2'b00;
    bus.up_penable = 2'b00;
    bus.up_pwrite  = 2'b00;
    bus.up_paddr   = '0;
    bus.up_pwdata  = '0;
    bus.up_pstrb   = '0;
    do_reset();

    check("rst_dn_psel",   bus.dn_psel,   0);
    check("rst_busy",      bus.busy,      0);
    check("rst_grant",     bus.grant,     0);
    check("rst_up_pready", bus.up_pready, 0);
    check("rst_up_prdata", bus.up_prdata, 0);

    // T1: req0 write, zero-wait completer.
    c_data = 32'hA5A5_0001; c_err = 1'b0; c_waits = 0;
    set_req(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    bus.up_psel = 2'b01;
    cyc();
    check("t1_c1_psel",    bus.dn_psel,    1);
    check("t1_c1_penable", bus.dn_penable, 0);
    check("t1_grant",      bus.grant,      0);
    check("t1_paddr",      bus.dn_paddr,   16'h0010);
    check("t1_pwdata",     bus.dn_pwdata,  32'hDEADBEEF);
    check("t1_pwrite",     bus.dn_pwrite,  1);
    bus.up_penable = 2'b01;
    cyc();
    check("t1_c2_penable", bus.dn_penable, 1);
    check("t1_c2_pready",  bus.up_pready,  2'b00);
    cyc();
    check("t1_c3_pready",  bus.up_pready,  2'b01);
    check("t1_c3_psel",    bus.dn_psel,    0);
    bus.up_psel = 2'b00; bus.up_penable = 2'b00;
    cyc();
    check("t1_c4_pready",  bus.up_pready,  2'b00);
    check("t1_c4_busy",    bus.busy,       0);

    // T2: both request right after reset; hold both for alternation and 4-cycle spacing.
    do_reset();
    set_req(0, 1'b1, 16'h0100, 32'h1111_1111, 4'h3);
    set_req(1, 1'b0, 16'h0200, 32'h2222_2222, 4'hC);
    bus.up_psel = 2'b11;
    n = 0; prev = 1'b0;
    for (int c = 0; c < 17; c++) begin
      cyc();
      if (bus.dn_psel && !prev && n < 8) begin
        g[n] = bus.grant; t[n] = c; a[n] = bus.dn_paddr; n++;
      end
      prev = bus.dn_psel;
    end
    check("t2_grant_count", n, 5);
    check("t2_grant0", g[0], 0);
    check("t2_grant1", g[1], 1);
    check("t2_grant2", g[2], 0);
    check("t2_grant3", g[3], 1);
    check("t2_addr0",  a[0], 16'h0100);
    check("t2_addr1",  a[1], 16'h0200);
    for (int i = 0; i < 4; i++) check("t2_spacing", t[i+1] - t[i], 4);
    // Fifth transfer (req0) is already in SETUP; dropping psel must not cancel it.
    bus.up_psel = 2'b00;
    lat = 0;
    while (bus.up_pready == 2'b00 && lat < 10) begin cyc(); lat++; end
    check("t2_violation_pready", bus.up_pready, 2'b01);
    cyc();

    // T3: req1 read, five wait states, error response.
    c_waits = 5; c_data = 32'h12345678; c_err = 1'b1;
    set_req(1, 1'b0, 16'h0A0C, 32'h0, 4'h0);
    bus.up_psel = 2'b10;
    wait_pready(40, lat);
    check("t3_latency", lat, 8);
    check("t3_pready",  bus.up_pready,  2'b10);
    check("t3_prdata",  bus.up_prdata,  32'h12345678);
    check("t3_pslverr", bus.up_pslverr, 1);
    bus.up_psel = 2'b00;
    c_data = 32'h0; c_err = 1'b0;
    cyc();
    check("t3_pready_one_cycle", bus.up_pready, 2'b00);
    check("t3_prdata_hold",      bus.up_prdata, 32'h12345678);

    // T4: reset asserted during ACCESS of a req0 transfer.
    c_never = 1'b1; c_waits = 0;
    set_req(0, 1'b1, 16'h0333, 32'h3333_3333, 4'hF);
    bus.up_psel = 2'b01;
    cyc();
    cyc();
    check("t4_in_access", bus.dn_penable, 1);
    #2;
    preset_n = 1'b0;
    #1;
    check("t4_rst_psel",    bus.dn_psel,    0);
    check("t4_rst_penable", bus.dn_penable, 0);
    check("t4_rst_pready",  bus.up_pready,  0);
    check("t4_rst_busy",    bus.busy,       0);
    check("t4_rst_paddr",   bus.dn_paddr,   0);
    bus.up_psel = 2'b00; c_never = 1'b0;
    cyc();
    cyc();
    preset_n = 1'b1;
    set_req(1, 1'b1, 16'h0444, 32'h4444_4444, 4'hF);
    bus.up_psel = 2'b11;
    cyc();
    check("t4_tie_grant", bus.grant,    0);
    check("t4_tie_paddr", bus.dn_paddr, 16'h0333);
    bus.up_psel = 2'b01;
    wait_pready(10, lat);
    check("t4_pready", bus.up_pready, 2'b01);
    bus.up_psel = 2'b00;
    cyc();

`ifdef APB_ARB_TIMEOUT_EN
    // T5: completer never ready -> abort after TMO ACCESS cycles.
    c_never = 1'b1; c_data = 32'h7777_7777; c_err = 1'b0;
    set_req(0, 1'b1, 16'h0040, 32'h5555_5555, 4'hF);
    bus.up_psel = 2'b01;
    wait_pready(40, lat);
    check("t5_abort_latency", lat, 10);
    check("t5_abort_pready",  bus.up_pready,  2'b01);
    check("t5_abort_pslverr", bus.up_pslverr, 1);
    check("t5_abort_prdata",  bus.up_prdata,  0);
    bus.up_psel = 2'b00; c_never = 1'b0;
    cyc();
    c_waits = 0; c_data = 32'h55AA55AA;
    set_req(1, 1'b0, 16'h0050, 32'h0, 4'h0);
    bus.up_psel = 2'b10;
    wait_pready(10, lat);
    check("t5_next_latency", lat, 3);
    check("t5_next_prdata",  bus.up_prdata,  32'h55AA55AA);
    check("t5_next_pslverr", bus.up_pslverr, 0);
    bus.up_psel = 2'b00;
    cyc();
    // Ready on the limit cycle wins over the abort.
    c_waits = 7; c_data = 32'h0BADF00D;
    bus.up_psel = 2'b01;
    wait_pready(40, lat);
    check("t5_edge_latency", lat, 10);
    check("t5_edge_prdata",  bus.up_prdata,  32'h0BADF00D);
    check("t5_edge_pslverr", bus.up_pslverr, 0);
    bus.up_psel = 2'b00;
    cyc();
`else
    // T6: long stall completes normally with the completer's error flag.
    c_waits = 1000; c_data = 32'hCAFEF00D; c_err = 1'b1;
    set_req(1, 1'b1, 16'h0F00, 32'h6666_6666, 4'h5);
    bus.up_psel = 2'b10;
    wait_pready(1100, lat);
    check("t6_latency", lat, 1003);
    check("t6_pready",  bus.up_pready,  2'b10);
    check("t6_prdata",  bus.up_prdata,  32'hCAFEF00D);
    check("t6_pslverr", bus.up_pslverr, 1);
    bus.up_psel = 2'b00; c_err = 1'b0;
    cyc();
`endif

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
